// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Holds default geometry, the FSM state type and the {CEN,WEN} access codes.
package dmem_pkg;

    localparam int DEF_DEPTH = 128;
    localparam int DEF_AW    = 7;
    localparam int DEF_DW    = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Active-low access decode on {CEN, WEN}
    localparam logic [1:0] ACC_RD = 2'b01;
    localparam logic [1:0] ACC_WR = 2'b00;

endpackage

// File: rtl/dmem_responder_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
// Ports: clk, rst, inc (count enable), cnt (value, sticks at all-ones).
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: async-read / sync-write word store with a clear
// sequence after reset, a valid/ready backdoor port and access counters.
// Ports: core side CEN/WEN/OEN/A/D/Q (active-low controls), busy while
// clearing, backdoor ld_* (valid/ready request, registered read data),
// rd_cnt/wr_cnt saturating core access counts.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    parameter int DW    = DEF_DW,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CEN,
    input  logic             WEN,
    input  logic             OEN,
    input  logic [AW-1:0]    A,
    input  logic [DW-1:0]    D,
    output logic [DW-1:0]    Q,
    output logic             busy,
    input  logic             ld_valid,
    output logic             ld_ready,
    input  logic             ld_we,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_wdata,
    output logic [DW-1:0]    ld_rdata,
    output logic             ld_rvalid,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] wr_cnt
);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_ptr;
    logic [DW-1:0]   mem [DEPTH];

    logic            idle;
    logic [1:0]      acc;
    logic            core_rd;
    logic            core_wr;
    logic            ld_fire;

    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [DW-1:0]   mem_wd;

    // idle gates every decode so X on the core pins during CLEAR is masked
    assign idle     = (state_q == ST_IDLE);
    assign acc      = {CEN, WEN};
    assign core_rd  = idle && (acc == ACC_RD);
    assign core_wr  = idle && (acc == ACC_WR);
    assign busy     = (state_q == ST_CLEAR);
    assign ld_ready = idle && CEN;
    assign ld_fire  = ld_valid && ld_ready;

    assign Q = (core_rd && !OEN) ? mem[A] : '0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_CLEAR: begin
                if (clr_ptr == AW'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Single write port: clear, then core, then backdoor
    always_comb begin
        mem_we = 1'b0;
        mem_wa = clr_ptr;
        mem_wd = '0;
        if (!idle) begin
            mem_we = 1'b1;
        end else if (core_wr) begin
            mem_we = 1'b1;
            mem_wa = A;
            mem_wd = D;
        end else if (ld_fire && ld_we) begin
            mem_we = 1'b1;
            mem_wa = ld_addr;
            mem_wd = ld_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr   <= '0;
            ld_rdata  <= '0;
            ld_rvalid <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_rvalid <= ld_fire && !ld_we;
            if (!idle) begin
                clr_ptr <= clr_ptr + AW'(1);
            end
            if (ld_fire && !ld_we) begin
                ld_rdata <= mem[ld_addr];
            end
        end
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_rd_cnt (
        .clk(clk),
        .rst(rst),
        .inc(core_rd && !OEN),
        .cnt(rd_cnt)
    );

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_wr_cnt (
        .clk(clk),
        .rst(rst),
        .inc(core_wr),
        .cnt(wr_cnt)
    );

endmodule
